// File: rtl/wakeup_scheduler.sv
// Per-lane latency shift arrays that replay each issued destination tag on the
// lane's wakeup port exactly io_issue_lat cycles after the micro-op was accepted.
module wakeup_scheduler #(
    parameter int NUM_WAKEUP_PORTS = 2,
    parameter int MAX_LAT          = 4,
    parameter int PREG_W           = 7,
    localparam int LAT_W           = $clog2(MAX_LAT + 1)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_WAKEUP_PORTS-1:0]                   io_issue_valid,
    input  logic [NUM_WAKEUP_PORTS-1:0][PREG_W-1:0]       io_issue_pdst,
    input  logic [NUM_WAKEUP_PORTS-1:0][LAT_W-1:0]        io_issue_lat,
    output logic [NUM_WAKEUP_PORTS-1:0]                   io_issue_ready,
    input  logic                                          io_flush,
    output logic [NUM_WAKEUP_PORTS-1:0]                   wakeup_ports_valid,
    output logic [NUM_WAKEUP_PORTS-1:0][PREG_W-1:0]       wakeup_ports_bits_pdst,
    output logic                                          io_busy
);

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] pdst;
    } entry_t;

    // Slot k of a lane broadcasts k cycles from now; slot 0 drives the port.
    entry_t slot_q [NUM_WAKEUP_PORTS][MAX_LAT];

    logic [NUM_WAKEUP_PORTS-1:0] lat_legal;
    logic [NUM_WAKEUP_PORTS-1:0] collide;
    logic [NUM_WAKEUP_PORTS-1:0] accept;

    // A write into slot L-1 would be overwritten by the occupant of slot L
    // shifting down, so an occupied slot L blocks latency L.
    always_comb begin
        // NOTE: every output of this block gets a default before the loops, so
        // no path leaves a variable unassigned and no latch is inferred.
        lat_legal      = '0;
        collide        = '0;
        io_issue_ready = '0;
        for (int i = 0; i < NUM_WAKEUP_PORTS; i++) begin
            lat_legal[i] = (io_issue_lat[i] != '0) &&
                           (io_issue_lat[i] <= LAT_W'(MAX_LAT));
            for (int k = 1; k < MAX_LAT; k++) begin
                if ((io_issue_lat[i] == LAT_W'(k)) && slot_q[i][k].valid)
                    collide[i] = 1'b1;
            end
            io_issue_ready[i] = !io_flush && lat_legal[i] && !collide[i];
        end
    end

    assign accept = io_issue_valid & io_issue_ready & {NUM_WAKEUP_PORTS{!io_flush}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the tag storage is reset along with the valid bits because the
            // broadcast tag is a direct register output that must read 0 in reset.
            for (int i = 0; i < NUM_WAKEUP_PORTS; i++)
                for (int k = 0; k < MAX_LAT; k++)
                    slot_q[i][k] <= '0;
        end else if (io_flush) begin
            for (int i = 0; i < NUM_WAKEUP_PORTS; i++)
                for (int k = 0; k < MAX_LAT; k++)
                    slot_q[i][k] <= '0;
        end else begin
            for (int i = 0; i < NUM_WAKEUP_PORTS; i++) begin
                for (int k = 0; k < MAX_LAT - 1; k++)
                    slot_q[i][k] <= slot_q[i][k+1];
                slot_q[i][MAX_LAT-1] <= '0;
                // NOTE: non-blocking assignments resolve last-write-wins, so the
                // capture below overrides the shift into the same slot.
                for (int k = 0; k < MAX_LAT; k++) begin
                    if (accept[i] && (io_issue_lat[i] == LAT_W'(k + 1)))
                        slot_q[i][k] <= {1'b1, io_issue_pdst[i]};
                end
            end
        end
    end

    always_comb begin
        wakeup_ports_valid     = '0;
        wakeup_ports_bits_pdst = '0;
        io_busy                = 1'b0;
        for (int i = 0; i < NUM_WAKEUP_PORTS; i++) begin
            wakeup_ports_valid[i]     = slot_q[i][0].valid;
            wakeup_ports_bits_pdst[i] = slot_q[i][0].pdst;
            for (int k = 0; k < MAX_LAT; k++)
                io_busy = io_busy | slot_q[i][k].valid;
        end
    end

endmodule
